// File: rtl/lia_square_demodulator.sv
// Lock-in square-wave mixer: a phase accumulator drives sin/cos-like square
// references that multiply each sample into I and Q products, 2-cycle latency.
package opo_package;
  localparam int word_width = 16;
endpackage

module lia_square_demodulator
  import opo_package::*;
#(
  parameter int phase_width = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic                          phase_clear,
  input  logic [phase_width-1:0]        phase_inc,
  input  logic [phase_width-1:0]        phase_offset,
  input  logic signed [word_width-1:0]  sample_in,
  input  logic                          sample_in_valid,
  output logic signed [word_width-1:0]  i_out,
  output logic signed [word_width-1:0]  q_out,
  output logic                          sample_out_valid,
  output logic                          ref_sign
);

  localparam int STAGES = 2;
  localparam int MSB    = phase_width - 1;
  localparam logic signed [word_width-1:0] SMIN = {1'b1, {(word_width-1){1'b0}}};
  localparam logic signed [word_width-1:0] SMAX = {1'b0, {(word_width-1){1'b1}}};

  logic [phase_width-1:0]        w_acc_base;
  logic [phase_width-1:0]        w_phase;
  logic [phase_width-1:0]        r_acc;
  logic [STAGES:1]               r_vld_pipe;
  logic signed [word_width-1:0]  r_s1_sample;
  logic                          r_s1_ineg;
  logic                          r_s1_qneg;
  logic                          r_s1_en;
  logic                          r_ref_sign;
  logic signed [word_width-1:0]  w_i_prod;
  logic signed [word_width-1:0]  w_q_prod;
  logic signed [word_width-1:0]  r_i_out;
  logic signed [word_width-1:0]  r_q_out;

  // -MIN is not representable, so it clamps to MAX.
  function automatic logic signed [word_width-1:0] neg_sat(
    input logic signed [word_width-1:0] x);
    return (x == SMIN) ? SMAX : -x;
  endfunction

  // A clear restarts the reference so a coincident sample sees phase 0.
  assign w_acc_base = phase_clear ? '0 : r_acc;
  assign w_phase    = w_acc_base + phase_offset;

  always_ff @(posedge clk) begin
    if (rst)                  r_acc <= '0;
    else if (sample_in_valid) r_acc <= w_acc_base + phase_inc;
    else if (phase_clear)     r_acc <= '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_pipe  <= '0;
      r_s1_sample <= '0;
      r_s1_ineg   <= 1'b0;
      r_s1_qneg   <= 1'b0;
      r_s1_en     <= 1'b0;
      r_ref_sign  <= 1'b0;
    end else begin
      r_vld_pipe <= {r_vld_pipe[STAGES-1:1], sample_in_valid};
      if (sample_in_valid) begin
        r_s1_sample <= sample_in;
        r_s1_ineg   <= w_phase[MSB];
        r_s1_qneg   <= w_phase[MSB] ^ w_phase[MSB-1];
        r_s1_en     <= enable;
        r_ref_sign  <= w_phase[MSB];
      end
    end
  end

  assign w_i_prod = (r_s1_en && r_s1_ineg) ? neg_sat(r_s1_sample) : r_s1_sample;
  assign w_q_prod = (r_s1_en && r_s1_qneg) ? neg_sat(r_s1_sample) : r_s1_sample;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_i_out <= '0;
      r_q_out <= '0;
    end else if (r_vld_pipe[1]) begin
      r_i_out <= w_i_prod;
      r_q_out <= w_q_prod;
    end
  end

  assign i_out            = r_i_out;
  assign q_out            = r_q_out;
  assign sample_out_valid = r_vld_pipe[STAGES];
  assign ref_sign         = r_ref_sign;

endmodule

// File: tb/tb_lia_square_demodulator.sv
// Bench for lia_square_demodulator: directed vector table, hand-built corner
// sequences and random traffic, all checked against a quadrant-level model.
module tb_lia_square_demodulator;

  logic               clk;
  logic               rst;
  logic               enable;
  logic               phase_clear;
  logic [31:0]        phase_inc;
  logic [31:0]        phase_offset;
  logic signed [15:0] sample_in;
  logic               sample_in_valid;
  logic signed [15:0] i_out;
  logic signed [15:0] q_out;
  logic               sample_out_valid;
  logic               ref_sign;

  int checks = 0;
  int errors = 0;

  lia_square_demodulator #(.phase_width(32)) dut (
    .clk(clk), .rst(rst), .enable(enable), .phase_clear(phase_clear),
    .phase_inc(phase_inc), .phase_offset(phase_offset),
    .sample_in(sample_in), .sample_in_valid(sample_in_valid),
    .i_out(i_out), .q_out(q_out), .sample_out_valid(sample_out_valid),
    .ref_sign(ref_sign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: reference state plus one pending product (second latency cycle).
  bit [31:0] m_acc;
  int        m_pv, m_pi, m_pq;
  int        m_ov, m_oi, m_oq, m_ref;

  function automatic int neg_sat(input int s);
    return (s == -32768) ? 32767 : -s;
  endfunction

  task automatic chk(input string nm, input int idx, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %0d want %0d", nm, idx, act, exp);
    end
  endtask

  task automatic model_edge(input logic r, v, en, clr, input int s,
                            input bit [31:0] inc, off);
    bit [31:0] p;
    int quad;
    bit ineg, qneg;
    if (r) begin
      m_acc = 0; m_pv = 0; m_pi = 0; m_pq = 0;
      m_ov = 0; m_oi = 0; m_oq = 0; m_ref = 0;
    end else begin
      m_ov = m_pv;
      if (m_pv != 0) begin m_oi = m_pi; m_oq = m_pq; end
      m_pv = v ? 1 : 0;
      if (v) begin
        p    = (clr ? 32'd0 : m_acc) + off;
        quad = int'(p / 32'h4000_0000);
        ineg = (quad >= 2);
        qneg = (quad == 1) || (quad == 2);
        m_pi = (en && ineg) ? neg_sat(s) : s;
        m_pq = (en && qneg) ? neg_sat(s) : s;
        m_ref = ineg ? 1 : 0;
        m_acc = (clr ? 32'd0 : m_acc) + inc;
      end else if (clr) begin
        m_acc = 0;
      end
    end
  endtask

  task automatic step(input logic r, v, en, clr, input int s,
                      input bit [31:0] inc, off, input int idx);
    rst = r; sample_in_valid = v; enable = en; phase_clear = clr;
    sample_in = s[15:0]; phase_inc = inc; phase_offset = off;
    @(posedge clk);
    model_edge(r, v, en, clr, s, inc, off);
    #1;
    chk("model_valid", idx, int'(sample_out_valid), m_ov);
    chk("model_i",     idx, int'(i_out),            m_oi);
    chk("model_q",     idx, int'(q_out),            m_oq);
    chk("model_ref",   idx, int'(ref_sign),         m_ref);
  endtask

  typedef struct {
    logic      r, v, en, clr;
    int        s;
    bit [31:0] inc, off;
    int        ev, ei, eq, eref;
  } vec_t;

  localparam bit [31:0] QT = 32'h4000_0000;
  localparam bit [31:0] HF = 32'h8000_0000;

  vec_t vecs[24];

  initial begin
    // Expected columns describe outputs after that row's edge, i.e. the
    // product of the previous row's sample.
    vecs[0]  = '{1'b1,1'b0,1'b1,1'b0,     0,QT, 0, 0,     0,     0,0};
    vecs[1]  = '{1'b0,1'b1,1'b1,1'b0,  1000,QT, 0, 0,     0,     0,0};
    vecs[2]  = '{1'b0,1'b1,1'b1,1'b0,  1000,QT, 0, 1,  1000,  1000,0};
    vecs[3]  = '{1'b0,1'b1,1'b1,1'b0,  1000,QT, 0, 1,  1000, -1000,1};
    vecs[4]  = '{1'b0,1'b1,1'b1,1'b0,  1000,QT, 0, 1, -1000, -1000,1};
    vecs[5]  = '{1'b0,1'b0,1'b1,1'b0,     0,QT, 0, 1, -1000,  1000,1};
    vecs[6]  = '{1'b0,1'b0,1'b1,1'b0,     0,QT, 0, 0, -1000,  1000,1};
    vecs[7]  = '{1'b1,1'b0,1'b1,1'b0,     0,QT,HF, 0,     0,     0,0};
    vecs[8]  = '{1'b0,1'b1,1'b1,1'b0,  1000,QT,HF, 0,     0,     0,1};
    vecs[9]  = '{1'b0,1'b1,1'b1,1'b0,  1000,QT,HF, 1, -1000, -1000,1};
    vecs[10] = '{1'b0,1'b1,1'b1,1'b0,  1000,QT,HF, 1, -1000,  1000,0};
    vecs[11] = '{1'b0,1'b1,1'b1,1'b0,  1000,QT,HF, 1,  1000,  1000,0};
    vecs[12] = '{1'b0,1'b0,1'b1,1'b0,     0,QT,HF, 1,  1000, -1000,0};
    vecs[13] = '{1'b1,1'b0,1'b1,1'b0,     0,HF,HF, 0,     0,     0,0};
    vecs[14] = '{1'b0,1'b1,1'b1,1'b0,-32768,HF,HF, 0,     0,     0,1};
    vecs[15] = '{1'b0,1'b1,1'b1,1'b0,-32768,HF,HF, 1, 32767, 32767,0};
    vecs[16] = '{1'b0,1'b0,1'b1,1'b0,     0,HF,HF, 1,-32768,-32768,0};
    vecs[17] = '{1'b1,1'b0,1'b1,1'b0,     0,QT, 0, 0,     0,     0,0};
    vecs[18] = '{1'b0,1'b1,1'b0,1'b0,     5,QT, 0, 0,     0,     0,0};
    vecs[19] = '{1'b0,1'b1,1'b0,1'b0,    -7,QT, 0, 1,     5,     5,0};
    vecs[20] = '{1'b0,1'b1,1'b0,1'b0,   123,QT, 0, 1,    -7,    -7,1};
    vecs[21] = '{1'b0,1'b1,1'b1,1'b0,  1000,QT, 0, 1,   123,   123,1};
    vecs[22] = '{1'b0,1'b0,1'b1,1'b0,     0,QT, 0, 1, -1000,  1000,1};
    vecs[23] = '{1'b0,1'b0,1'b1,1'b0,     0,QT, 0, 0, -1000,  1000,1};

    rst = 1'b1; enable = 1'b1; phase_clear = 1'b0; sample_in_valid = 1'b0;
    sample_in = '0; phase_inc = '0; phase_offset = '0;
    @(posedge clk); #1;

    for (int k = 0; k < 24; k++) begin
      step(vecs[k].r, vecs[k].v, vecs[k].en, vecs[k].clr, vecs[k].s,
           vecs[k].inc, vecs[k].off, k);
      chk("tbl_valid", k, int'(sample_out_valid), vecs[k].ev);
      chk("tbl_i",     k, int'(i_out),            vecs[k].ei);
      chk("tbl_q",     k, int'(q_out),            vecs[k].eq);
      chk("tbl_ref",   k, int'(ref_sign),         vecs[k].eref);
    end

    // Gapped valid, then a clear coincident with a sample.
    step(1, 0, 1, 0, 0, 32'h1000_0000, 32'h2000_0000, 100);
    for (int c = 0; c < 9; c++) begin
      logic v;
      v = (c == 0 || c == 3 || c == 4 || c == 7);
      step(0, v, 1, (c == 7), 100 + c, 32'h1000_0000, 32'h2000_0000, 101 + c);
      if (c == 1) chk("gap_valid_c1", c, int'(sample_out_valid), 1);
      if (c == 2) chk("gap_valid_c2", c, int'(sample_out_valid), 0);
      if (c == 8) begin
        chk("clr_valid", c, int'(sample_out_valid), 1);
        chk("clr_q",     c, int'(q_out),            107);
      end
    end

    // Reset while two samples are in flight.
    step(1, 0, 1, 0, 0, QT, 0, 200);
    step(0, 1, 1, 0, 300, QT, 0, 201);
    step(0, 1, 1, 0, 400, QT, 0, 202);
    step(1, 0, 1, 0, 0, QT, 0, 203);
    chk("rst_valid", 0, int'(sample_out_valid), 0);
    chk("rst_i",     0, int'(i_out),            0);
    chk("rst_ref",   0, int'(ref_sign),         0);
    step(0, 0, 1, 0, 0, QT, 0, 204);
    chk("rst_flush", 0, int'(sample_out_valid), 0);
    step(0, 1, 1, 0, -50, QT, 0, 205);
    step(0, 0, 1, 0, 0, QT, 0, 206);
    chk("rst_phase0_i", 0, int'(i_out), -50);
    chk("rst_phase0_q", 0, int'(q_out), -50);

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      logic r, v, en, clr;
      int s;
      bit [31:0] inc, off;
      r   = ($urandom_range(63) == 0);
      v   = ($urandom_range(3) != 0);
      en  = ($urandom_range(7) != 0);
      clr = ($urandom_range(15) == 0);
      case ($urandom_range(15))
        0:       s = -32768;
        1:       s = 32767;
        default: s = $urandom_range(65535) - 32768;
      endcase
      inc = ($urandom_range(3) == 0) ? QT * $urandom_range(3) : $urandom;
      off = ($urandom_range(3) == 0) ? QT * $urandom_range(3) : $urandom;
      step(r, v, en, clr, s, inc, off, 1000 + n);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
